// File: rtl/fir_piso_serializer.sv
// fir_piso_serializer
// Stereo output stage behind the FIR left/right accumulators. Each channel
// converts its wide accumulator result to a saturated output sample and holds
// it; a Frame request shifts out {left, right} MSB first on a single line.
// Sticky flags report saturation, overwritten samples and Frame requests that
// arrive while a word is still being shifted.
module fir_piso_serializer #(
    parameter int W_ACC = 40,
    parameter int W_OUT = 16,
    parameter int FRAC  = 16
) (
    input  logic             Sclk,
    input  logic             Clear_n,
    input  logic             enable_PISO_L,
    input  logic             enable_PISO_R,
    input  logic [W_ACC-1:0] accL,
    input  logic [W_ACC-1:0] accR,
    input  logic             Frame,
    input  logic             clr_flags,
    output logic             Dout,
    output logic             OutReady,
    output logic             satL,
    output logic             satR,
    output logic             ovrL,
    output logic             ovrR,
    output logic             frame_err
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int W_FRAME = 2 * W_OUT;
    localparam int W_CNT   = $clog2(W_FRAME);
    // Lowest accumulator bit that must agree with the sign bit for the
    // sample to be representable without saturation.
    localparam int SAT_LO  = FRAC + W_OUT - 1;
    localparam int W_TOP   = W_ACC - SAT_LO;

    localparam logic [W_CNT-1:0] LAST_BIT = W_CNT'(W_FRAME - 1);
    localparam logic [W_OUT-1:0] MAX_POS  = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic [W_OUT-1:0] MAX_NEG  = {1'b1, {(W_OUT-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateType;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    stateType             state;
    stateType             stateNext;
    logic [W_FRAME-1:0]   sreg;
    logic [W_FRAME-1:0]   sregNext;
    logic [W_CNT-1:0]     bitCnt;
    logic [W_CNT-1:0]     bitCntNext;
    logic                 doutNext;
    logic                 outReadyNext;

    logic [W_OUT-1:0]     holdL;
    logic [W_OUT-1:0]     holdR;
    logic [W_OUT-1:0]     holdLNext;
    logic [W_OUT-1:0]     holdRNext;
    logic                 validL;
    logic                 validR;
    logic                 validLNext;
    logic                 validRNext;

    // Frame accepted this cycle: sreg loads the pre-capture hold values.
    logic                 frameLoad;

    // Flag-set events for this cycle
    logic                 satLSet;
    logic                 satRSet;
    logic                 ovrLSet;
    logic                 ovrRSet;
    logic                 frameErrSet;

    // ------------------------------------------------------------------
    // Conversion: accumulator -> saturated, truncated output sample
    // ------------------------------------------------------------------
    logic [W_TOP-1:0]     topL;
    logic [W_TOP-1:0]     topR;
    logic                 satCondL;
    logic                 satCondR;
    logic [W_OUT-1:0]     sampleL;
    logic [W_OUT-1:0]     sampleR;

    // The fractional bits below the output LSB are discarded by truncation.
    logic [2*FRAC-1:0]    unusedFracBits;
    assign unusedFracBits = {accL[FRAC-1:0], accR[FRAC-1:0]};

    assign topL = accL[W_ACC-1:SAT_LO];
    assign topR = accR[W_ACC-1:SAT_LO];

    // Representable only when every bit from the sign down to the sample MSB
    // agrees; otherwise clamp toward the sign of the accumulator.
    assign satCondL = !((&topL) || !(|topL));
    assign satCondR = !((&topR) || !(|topR));

    assign sampleL = satCondL ? (accL[W_ACC-1] ? MAX_NEG : MAX_POS)
                              : accL[SAT_LO:FRAC];
    assign sampleR = satCondR ? (accR[W_ACC-1] ? MAX_NEG : MAX_POS)
                              : accR[SAT_LO:FRAC];

    // ------------------------------------------------------------------
    // Frame FSM: next state, shift datapath and serial outputs
    // ------------------------------------------------------------------
    // Decide the next state, shift-register contents and serial outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave a latch behind.
        stateNext    = state;
        sregNext     = sreg;
        bitCntNext   = bitCnt;
        doutNext     = 1'b0;
        outReadyNext = 1'b0;
        frameLoad    = 1'b0;
        frameErrSet  = 1'b0;

        case (state)
            IDLE: begin
                // Load is unconditional: a channel without a fresh sample
                // simply resends whatever it last held.
                if (Frame) begin
                    frameLoad  = 1'b1;
                    sregNext   = {holdL, holdR};
                    bitCntNext = '0;
                    stateNext  = SHIFT;
                end
            end

            SHIFT: begin
                doutNext     = sreg[W_FRAME-1];
                outReadyNext = 1'b1;
                sregNext     = {sreg[W_FRAME-2:0], 1'b0};
                bitCntNext   = bitCnt + W_CNT'(1);
                // A request during any shift cycle, including the last one,
                // is dropped and reported; the word in flight is untouched.
                frameErrSet  = Frame;
                if (bitCnt == LAST_BIT) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register plus shift datapath; outputs are registered.
    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            state    <= IDLE;
            sreg     <= '0;
            bitCnt   <= '0;
            Dout     <= 1'b0;
            OutReady <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // the values present before the edge regardless of order.
            state    <= stateNext;
            sreg     <= sregNext;
            bitCnt   <= bitCntNext;
            Dout     <= doutNext;
            OutReady <= outReadyNext;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel capture: hold register and valid bit
    // ------------------------------------------------------------------
    // Compute capture results; a same-cycle capture wins over the Frame clear.
    always_comb begin
        holdLNext  = holdL;
        holdRNext  = holdR;
        validLNext = validL;
        validRNext = validR;

        if (enable_PISO_L) begin
            holdLNext  = sampleL;
            validLNext = 1'b1;
        end else if (frameLoad) begin
            validLNext = 1'b0;
        end

        if (enable_PISO_R) begin
            holdRNext  = sampleR;
            validRNext = 1'b1;
        end else if (frameLoad) begin
            validRNext = 1'b0;
        end
    end

    // Hold registers and valid bits for both channels.
    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            // NOTE: the hold registers are reset as well, because a Frame
            // after reset must transmit zeros rather than stale data.
            holdL  <= '0;
            holdR  <= '0;
            validL <= 1'b0;
            validR <= 1'b0;
        end else begin
            holdL  <= holdLNext;
            holdR  <= holdRNext;
            validL <= validLNext;
            validR <= validRNext;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags
    // ------------------------------------------------------------------
    assign satLSet = enable_PISO_L && satCondL;
    assign satRSet = enable_PISO_R && satCondR;
    // Overrun only when the unsent sample is really lost: if the Frame load
    // takes it in the same cycle, the new capture is not an overwrite.
    assign ovrLSet = enable_PISO_L && validL && !frameLoad;
    assign ovrRSet = enable_PISO_R && validR && !frameLoad;

    // Sticky flags: a set event in the same cycle overrides clr_flags.
    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            satL      <= 1'b0;
            satR      <= 1'b0;
            ovrL      <= 1'b0;
            ovrR      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            satL      <= satLSet     || (satL      && !clr_flags);
            satR      <= satRSet     || (satR      && !clr_flags);
            ovrL      <= ovrLSet     || (ovrL      && !clr_flags);
            ovrR      <= ovrRSet     || (ovrR      && !clr_flags);
            frame_err <= frameErrSet || (frame_err && !clr_flags);
        end
    end

endmodule

// File: tb/tb_fir_piso_serializer.sv
// tb_fir_piso_serializer
// Directed scenarios followed by random traffic, all compared cycle by cycle
// against an arithmetic reference model of the serializer.
module tb_fir_piso_serializer;

    logic        Sclk;
    logic        Clear_n;
    logic        enable_PISO_L;
    logic        enable_PISO_R;
    logic [39:0] accL;
    logic [39:0] accR;
    logic        Frame;
    logic        clr_flags;
    logic        Dout;
    logic        OutReady;
    logic        satL;
    logic        satR;
    logic        ovrL;
    logic        ovrR;
    logic        frame_err;

    fir_piso_serializer #(
        .W_ACC (40),
        .W_OUT (16),
        .FRAC  (16)
    ) dut (
        .Sclk          (Sclk),
        .Clear_n       (Clear_n),
        .enable_PISO_L (enable_PISO_L),
        .enable_PISO_R (enable_PISO_R),
        .accL          (accL),
        .accR          (accR),
        .Frame         (Frame),
        .clr_flags     (clr_flags),
        .Dout          (Dout),
        .OutReady      (OutReady),
        .satL          (satL),
        .satR          (satR),
        .ovrL          (ovrL),
        .ovrR          (ovrR),
        .frame_err     (frame_err)
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] mHoldL, mHoldR;
    bit          mValidL, mValidR;
    bit          mSatL, mSatR, mOvrL, mOvrR, mFrameErr;
    int          mRemaining;
    logic [31:0] mWord;
    bit          expDout, expReady;

    // Observed serial word and OutReady length
    logic [31:0] rxWord;
    int          readyCnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scale by 2^-16 arithmetically, then clamp to the signed 16-bit range.
    function automatic logic [15:0] toSample(input logic [39:0] acc, output bit sat);
        longint v;
        v = longint'($signed(acc));
        v = v >>> 16;
        if (v > 32767) begin
            sat = 1'b1;
            return 16'h7FFF;
        end else if (v < -32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        sat = 1'b0;
        return 16'(v);
    endfunction

    task automatic modelReset();
        mHoldL = '0; mHoldR = '0;
        mValidL = 0; mValidR = 0;
        mSatL = 0; mSatR = 0; mOvrL = 0; mOvrR = 0; mFrameErr = 0;
        mRemaining = 0; mWord = '0;
        expDout = 0; expReady = 0;
    endtask

    // Effect of one rising edge with the given inputs.
    task automatic modelEdge(input bit fr, input bit enL, input logic [39:0] aL,
                             input bit enR, input logic [39:0] aR, input bit clr);
        bit frameLoad, errSet, sL, sR, ovrSetL, ovrSetR;
        logic [15:0] smpL, smpR;
        frameLoad = 0;
        errSet    = 0;
        if (mRemaining > 0) begin
            expDout  = mWord[mRemaining-1];
            expReady = 1;
            mRemaining--;
            errSet   = fr;
        end else begin
            expDout  = 0;
            expReady = 0;
            if (fr) begin
                mWord      = {mHoldL, mHoldR};
                mRemaining = 32;
                frameLoad  = 1;
            end
        end
        smpL = toSample(aL, sL);
        smpR = toSample(aR, sR);
        ovrSetL = enL && mValidL && !frameLoad;
        ovrSetR = enR && mValidR && !frameLoad;
        mSatL     = (enL && sL) || (mSatL && !clr);
        mSatR     = (enR && sR) || (mSatR && !clr);
        mOvrL     = ovrSetL || (mOvrL && !clr);
        mOvrR     = ovrSetR || (mOvrR && !clr);
        mFrameErr = errSet || (mFrameErr && !clr);
        if (enL) begin mHoldL = smpL; mValidL = 1; end
        else if (frameLoad) mValidL = 0;
        if (enR) begin mHoldR = smpR; mValidR = 1; end
        else if (frameLoad) mValidR = 0;
    endtask

    // One clock: drive at the falling edge, compare at the next falling edge.
    task automatic tick(input bit fr, input bit enL, input logic [39:0] aL,
                        input bit enR, input logic [39:0] aR, input bit clr);
        Frame = fr; enable_PISO_L = enL; accL = aL;
        enable_PISO_R = enR; accR = aR; clr_flags = clr;
        modelEdge(fr, enL, aL, enR, aR, clr);
        @(posedge Sclk);
        @(negedge Sclk);
        check("dout", 32'(Dout), 32'(expDout));
        check("ready", 32'(OutReady), 32'(expReady));
        check("flags", 32'({satL, satR, ovrL, ovrR, frame_err}),
              32'({mSatL, mSatR, mOvrL, mOvrR, mFrameErr}));
        if (OutReady) begin
            rxWord = {rxWord[30:0], Dout};
            readyCnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, '0, 0, '0, 0);
    endtask

    task automatic clearFlags();
        tick(0, 0, '0, 0, '0, 1);
    endtask

    // Reset asserted between edges; outputs must drop without a clock.
    task automatic doReset();
        Frame = 0; enable_PISO_L = 0; enable_PISO_R = 0;
        accL = '0; accR = '0; clr_flags = 0;
        Clear_n = 0;
        #1;
        modelReset();
        check("rst_dout", 32'(Dout), 32'(0));
        check("rst_ready", 32'(OutReady), 32'(0));
        check("rst_flags", 32'({satL, satR, ovrL, ovrR, frame_err}), 32'(0));
        @(posedge Sclk);
        @(negedge Sclk);
        Clear_n = 1;
    endtask

    task automatic sendFrame(input logic [31:0] expWord, input string tag);
        readyCnt = 0;
        tick(1, 0, '0, 0, '0, 0);
        idle(32);
        check(tag, rxWord, expWord);
        check({tag, "_len"}, 32'(readyCnt), 32'(32));
    endtask

    function automatic logic [39:0] randAcc();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return {8'($urandom), r};
            1:       return {{8{r[31]}}, r};
            2:       return {{7{r[31]}}, ~r[31], r};
            default: return 40'h0;
        endcase
    endfunction

    initial begin
        Clear_n = 0; Frame = 0; enable_PISO_L = 0; enable_PISO_R = 0;
        accL = '0; accR = '0; clr_flags = 0;
        rxWord = '0; readyCnt = 0;
        modelReset();
        @(negedge Sclk);
        doReset();

        // Basic frame: left in range, right saturating positive
        tick(0, 1, 40'h00_1234_ABCD, 1, 40'h00_A5A5_0000, 0);
        check("satR_basic", 32'(satR), 32'(1));
        sendFrame(32'h1234_7FFF, "basic_word");

        // Saturation boundaries on the left channel
        clearFlags();
        tick(0, 1, 40'hFF_8000_0000, 0, '0, 0);
        check("satL_min", 32'(satL), 32'(0));
        sendFrame(32'h8000_7FFF, "min_word");
        tick(0, 1, 40'hFE_0000_0000, 0, '0, 0);
        check("satL_neg", 32'(satL), 32'(1));
        sendFrame(32'h8000_7FFF, "neg_sat_word");
        clearFlags();
        tick(0, 1, 40'h00_7FFF_FFFF, 0, '0, 0);
        check("satL_max", 32'(satL), 32'(0));
        sendFrame(32'h7FFF_7FFF, "max_word");

        // Overrun: second capture overwrites an unsent sample
        clearFlags();
        tick(0, 1, 40'h00_0011_1100, 0, '0, 0);
        tick(0, 1, 40'h00_0022_2200, 0, '0, 0);
        check("ovrL_set", 32'(ovrL), 32'(1));
        sendFrame(32'h0022_7FFF, "ovr_word");

        // Capture in the same cycle as the Frame load is not an overrun
        clearFlags();
        tick(0, 1, 40'h00_0033_0000, 0, '0, 0);
        readyCnt = 0;
        tick(1, 1, 40'h00_0044_0000, 0, '0, 0);
        check("ovrL_same_cycle", 32'(ovrL), 32'(0));
        idle(32);
        check("old_sent", rxWord, 32'h0033_7FFF);
        sendFrame(32'h0044_7FFF, "new_held");

        // Frame during shifting at bitcnt=10
        clearFlags();
        readyCnt = 0;
        tick(1, 0, '0, 0, '0, 0);
        idle(10);
        tick(1, 0, '0, 0, '0, 0);
        idle(21);
        check("ferr_word", rxWord, 32'h0044_7FFF);
        check("ferr_flag", 32'(frame_err), 32'(1));
        check("ferr_len", 32'(readyCnt), 32'(32));
        sendFrame(32'h0044_7FFF, "after_ferr");

        // Frame on the last shift cycle is also rejected
        clearFlags();
        tick(1, 0, '0, 0, '0, 0);
        idle(31);
        tick(1, 0, '0, 0, '0, 0);
        check("ferr_last", 32'(frame_err), 32'(1));
        sendFrame(32'h0044_7FFF, "after_last");

        // Flag clear priority
        tick(0, 1, 40'hFE_0000_0000, 0, '0, 1);
        check("clr_prio", 32'(satL), 32'(1));
        clearFlags();
        check("clr_alone", 32'(satL), 32'(0));

        // Reset in the middle of a frame
        tick(1, 0, '0, 0, '0, 0);
        idle(5);
        doReset();
        idle(5);
        sendFrame(32'h0000_0000, "after_reset");

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) doReset();
            tick($urandom_range(0, 19) == 0,
                 $urandom_range(0, 5) == 0, randAcc(),
                 $urandom_range(0, 5) == 0, randAcc(),
                 $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_piso_serializer.md
Name: fir_piso_serializer

Overview:
- Stereo output stage directly downstream of the FIR ALU controller and its left/right accumulators.
- On each channel's one-cycle PISO enable pulse, it captures the 40-bit accumulator result and converts it to a saturated 16-bit sample. It holds one sample per channel.
- On a Frame pulse it shifts out a 32-bit word, left channel first, MSB first, on a single serial line.
- Sticky flags report saturation, overrun and framing errors.

Parameters:
- W_ACC, 40, accumulator width.
- W_OUT, 16, output sample width.
- FRAC, 16, bit index of the output LSB within the accumulator. The sample is acc[FRAC+W_OUT-1:FRAC].

Ports:
- Sclk  in  1  clock; all flops update on the rising edge.
- Clear_n  in  1  asynchronous, active-low reset.
- enable_PISO_L  in  1  one-cycle pulse; accL is valid in that cycle.
- enable_PISO_R  in  1  one-cycle pulse; accR is valid in that cycle.
- accL  in  W_ACC  left accumulator result, two's complement.
- accR  in  W_ACC  right accumulator result, two's complement.
- Frame  in  1  one-cycle frame-start request.
- clr_flags  in  1  synchronous clear of all sticky flags.
- Dout  out  1  serial data.
- OutReady  out  1  high while Dout carries a valid frame bit.
- satL, satR  out  1  sticky: a captured sample was saturated.
- ovrL, ovrR  out  1  sticky: a held sample was overwritten before transmission.
- frame_err  out  1  sticky: Frame arrived while shifting.

Behaviour:
- Reset (Clear_n=0, asynchronous):
  - state=IDLE; Dout=0, OutReady=0; all flags=0.
  - holdL=holdR=0, validL=validR=0, sreg=0, bitcnt=0.
  - Applies mid-frame: the frame is abandoned, and transmission does not resume after release.
- Conversion (combinational, per channel):
  - Saturation condition: acc[W_ACC-1:FRAC+W_OUT-1] not all-equal.
  - If saturated: sample = 16'h7FFF when acc[W_ACC-1]=0, else 16'h8000.
  - Otherwise: sample = acc[FRAC+W_OUT-1:FRAC] (truncation, no rounding).
- Capture on enable_PISO_X:
  - holdX <= sample, validX <= 1.
  - satX set if the sample was saturated.
  - ovrX set if validX was already 1 and that held sample is not being loaded into sreg in the same cycle.
- State machine, two states:
  - IDLE:
    - Frame=1: sreg <= {holdL, holdR}, using the pre-capture hold values; validL/validR <= 0.
    - Exception: a channel capturing in that same cycle keeps valid=1 with its new sample.
    - bitcnt <= 0; go to SHIFT.
    - Frame load is unconditional. A channel with valid=0 retransmits its last held value; no flag is raised.
  - SHIFT:
    - Each cycle: Dout <= sreg[31], OutReady <= 1, sreg <= sreg<<1, bitcnt <= bitcnt+1.
    - After the bit with bitcnt=31 has been driven: go to IDLE, and Dout <= 0, OutReady <= 0 on the next edge.
- Latency:
  - Frame sampled at edge N: first bit (holdL[15]) is on Dout after edge N+1.
  - Last bit (holdR[0]) is on Dout after edge N+32. OutReady is high for exactly 32 cycles.
  - Capture-to-hold: 1 cycle.
- Frame during SHIFT is ignored and sets frame_err. The frame in progress is unaffected.
- Frame on the last SHIFT cycle (bitcnt=31) is also ignored and flagged. The next Frame is accepted once the block is back in IDLE.
- Back-to-back frames have a minimum period of 33 cycles.
- Captures are accepted in any state. They never disturb sreg while shifting.
- clr_flags clears all sticky flags. A flag-setting event in the same cycle takes priority, so the flag ends up set.
- Both channels are independent. Simultaneous enable_PISO_L and enable_PISO_R are both captured.

Test Plan:
- Basic frame:
  - Stimulus: accL=40'h00_1234_ABCD (enable_PISO_L), accR=40'h00_A5A5_0000 treated as positive-saturating: bits[39:31] = 0 0000000 1 are not all equal.
  - Response: holdR=16'h7FFF, satR=1. Frame then yields Dout = 0001001000110100 0111111111111111, OutReady high for 32 cycles starting at N+1.
- Saturation boundaries:
  - accL=40'hFF_8000_0000 -> 16'h8000, satL=0.
  - accL=40'hFE_0000_0000 -> 16'h8000, satL=1.
  - accL=40'h00_7FFF_FFFF -> 16'h7FFF, satL=0.
- Overrun:
  - Two enable_PISO_L pulses without a Frame -> ovrL=1; the second sample is transmitted.
  - enable_PISO_L in the same cycle as a Frame load -> ovrL stays 0; the old sample is sent, the new sample is held with validL=1.
- Frame error: Frame at bitcnt=10 -> frame_err=1; the 32-bit word completes unchanged; the next Frame is accepted 33 cycles after the first.
- Reset mid-frame: Clear_n=0 at bitcnt=5 -> Dout=0, OutReady=0 immediately; after release, no output until a new Frame, which transmits 32'h0000_0000.
- Flag clear priority: clr_flags=1 in the same cycle as a saturating capture -> satL=1; clr_flags alone on the next cycle -> satL=0.
